vga_timing_aligned: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/vga_axis_counter.sv | 32 +++
 rtl/vga_timing_aligned.sv | 129 ++++++++++++
 tb/tb_vga_timing_aligned.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing types and helpers for the VGA raster generator.
// One timing_t describes one axis: active, front porch, sync width, back porch.
package vga_timing_pkg;

   typedef struct packed {
      int unsigned active;
      int unsigned front;
      int unsigned sync;
      int unsigned back;
   } timing_t;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic de;
   } sync_vec_t;

   localparam timing_t VGA_640x480_H = '{active: 640, front: 16, sync: 96, back: 48};
   localparam timing_t VGA_640x480_V = '{active: 480, front: 10, sync: 2,  back: 33};

   function automatic int unsigned total(timing_t t);
      return t.active + t.front + t.sync + t.back;
   endfunction

   function automatic logic sync_active(int unsigned cnt, timing_t t);
      return (cnt >= t.active + t.front) && (cnt < t.active + t.front + t.sync);
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counts on en, wraps at total-1 and decodes active/sync regions.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter timing_t     cfg = VGA_640x480_H,
   parameter int unsigned w   = $clog2(total(VGA_640x480_H))
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [w-1:0] cnt,
   output logic         wrap,
   output logic         active,
   output logic         sync_raw
);

   localparam int unsigned last = total(cfg) - 1;

   // wrap already includes en so it can directly enable the next axis
   assign wrap     = en && (32'(cnt) == last);
   assign active   = 32'(cnt) < cfg.active;
   assign sync_raw = sync_active(32'(cnt), cfg);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= wrap ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/vga_timing_aligned.sv
// VGA timing generator with pixel-rate divider, x/y counters and sync/blank
// outputs delayed by pipe_stages pixel slots to match registered colour.
module vga_timing_aligned
   import vga_timing_pkg::*;
#(
   parameter int unsigned clk_mhz     = 50,
   parameter int unsigned pixel_mhz   = 25,
   parameter int unsigned h_active    = 640,
   parameter int unsigned h_front     = 16,
   parameter int unsigned h_sync      = 96,
   parameter int unsigned h_back      = 48,
   parameter int unsigned v_active    = 480,
   parameter int unsigned v_front     = 10,
   parameter int unsigned v_sync      = 2,
   parameter int unsigned v_back      = 33,
   parameter int unsigned hsync_pol   = 0,
   parameter int unsigned vsync_pol   = 0,
   parameter int unsigned pipe_stages = 1,
   parameter int unsigned w_x         = $clog2(h_active + h_front + h_sync + h_back),
   parameter int unsigned w_y         = $clog2(v_active + v_front + v_sync + v_back)
) (
   input  logic           clk,
   input  logic           rst,
   output logic           pixel_en,
   output logic           pixel_clk,
   output logic [w_x-1:0] x,
   output logic [w_y-1:0] y,
   output logic           display_on_early,
   output logic           line_start,
   output logic           frame_start,
   output logic [15:0]    frame_cnt,
   output logic           hsync,
   output logic           vsync,
   output logic           display_on
);

   localparam int unsigned R        = clk_mhz / pixel_mhz;
   localparam int unsigned dw       = (R > 1) ? $clog2(R) : 1;
   localparam int unsigned n_stages = (pipe_stages == 0) ? 1 : pipe_stages;
   localparam logic        hs_on    = (hsync_pol != 0);
   localparam logic        vs_on    = (vsync_pol != 0);
   localparam timing_t     h_cfg    = '{active: h_active, front: h_front, sync: h_sync, back: h_back};
   localparam timing_t     v_cfg    = '{active: v_active, front: v_front, sync: v_sync, back: v_back};
   localparam sync_vec_t   idle     = '{hsync: !hs_on, vsync: !vs_on, de: 1'b0};

   if ((clk_mhz % pixel_mhz) != 0 || clk_mhz < pixel_mhz) begin : g_bad_ratio
      $error("clk_mhz must be an integer multiple (>= 1) of pixel_mhz");
   end
   if (pipe_stages > 4) begin : g_bad_pipe
      $error("pipe_stages must be in 0..4");
   end

   logic [dw-1:0] div;
   logic [dw-1:0] div_next;
   logic          x_wrap;
   logic          unused_y_wrap;
   logic          h_act, v_act, h_sync_raw, v_sync_raw;
   sync_vec_t     raw;
   sync_vec_t     stage [n_stages];

   assign div_next = (32'(div) == R - 1) ? '0 : div + 1'b1;

   // pixel_clk is decoded from div_next so its registered value is high while div >= R/2
   always_ff @(posedge clk) begin
      if (rst) begin
         div       <= '0;
         pixel_en  <= 1'b0;
         pixel_clk <= 1'b0;
      end else begin
         div       <= div_next;
         pixel_en  <= (32'(div) == R - 1);
         pixel_clk <= (R >= 2) && (32'(div_next) >= R / 2);
      end
   end

   vga_axis_counter #(.cfg(h_cfg), .w(w_x)) u_x_counter (
      .clk      (clk),
      .rst      (rst),
      .en       (pixel_en),
      .cnt      (x),
      .wrap     (x_wrap),
      .active   (h_act),
      .sync_raw (h_sync_raw)
   );

   vga_axis_counter #(.cfg(v_cfg), .w(w_y)) u_y_counter (
      .clk      (clk),
      .rst      (rst),
      .en       (x_wrap),
      .cnt      (y),
      .wrap     (unused_y_wrap),
      .active   (v_act),
      .sync_raw (v_sync_raw)
   );

   assign display_on_early = !rst && h_act && v_act;
   assign line_start       = pixel_en && (x == '0);
   assign frame_start      = line_start && (y == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt <= '0;
      end else if (frame_start) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end

   always_comb begin
      raw       = idle;
      raw.hsync = h_sync_raw ? hs_on : !hs_on;
      raw.vsync = v_sync_raw ? vs_on : !vs_on;
      raw.de    = h_act && v_act;
   end

   // With no downstream latency a single free-running register still isolates the pins
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(n_stages); i++) stage[i] <= idle;
      end else if (pipe_stages == 0 || pixel_en) begin
         stage[0] <= raw;
         for (int i = 1; i < int'(n_stages); i++) stage[i] <= stage[i-1];
      end
   end

   assign hsync      = stage[n_stages-1].hsync;
   assign vsync      = stage[n_stages-1].vsync;
   assign display_on = stage[n_stages-1].de;

endmodule

// File: tb/tb_vga_timing_aligned.sv
// Directed bench: default 640x480 timing, a 4:1 divider with no delay, and a
// tiny raster used for multi-frame counting and vertical sync checks.
module tb_vga_timing_aligned;

   logic clk   = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   logic rst_c = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic a_pe, a_pclk, a_doe, a_ls, a_fs, a_hs, a_vs, a_de;
   logic [9:0] a_x, a_y;
   logic [15:0] a_fc;
   logic b_pe, b_pclk, b_doe, b_ls, b_fs, b_hs, b_vs, b_de;
   logic [9:0] b_x, b_y;
   logic [15:0] b_fc;
   logic c_pe, c_pclk, c_doe, c_ls, c_fs, c_hs, c_vs, c_de;
   logic [3:0] c_x, c_y;
   logic [15:0] c_fc;

   vga_timing_aligned dut_a (
      .clk(clk), .rst(rst_a), .pixel_en(a_pe), .pixel_clk(a_pclk), .x(a_x), .y(a_y),
      .display_on_early(a_doe), .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_fc),
      .hsync(a_hs), .vsync(a_vs), .display_on(a_de)
   );

   vga_timing_aligned #(.clk_mhz(100), .pixel_mhz(25), .pipe_stages(0)) dut_b (
      .clk(clk), .rst(rst_b), .pixel_en(b_pe), .pixel_clk(b_pclk), .x(b_x), .y(b_y),
      .display_on_early(b_doe), .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc),
      .hsync(b_hs), .vsync(b_vs), .display_on(b_de)
   );

   vga_timing_aligned #(
      .h_active(8), .h_front(2), .h_sync(3), .h_back(3),
      .v_active(6), .v_front(1), .v_sync(2), .v_back(1),
      .hsync_pol(1), .vsync_pol(0), .pipe_stages(2), .w_x(4), .w_y(4)
   ) dut_c (
      .clk(clk), .rst(rst_c), .pixel_en(c_pe), .pixel_clk(c_pclk), .x(c_x), .y(c_y),
      .display_on_early(c_doe), .line_start(c_ls), .frame_start(c_fs), .frame_cnt(c_fc),
      .hsync(c_hs), .vsync(c_vs), .display_on(c_de)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int t0, gap, first_hs_x, de_fall_x, de_rise_x, hs_low, early_bad, delay_bad;
      int inv_bad, pe_bad, last_pe, prev_x, wrap_x, wrap_y, max_x, first;
      int fs_n, ls_n, vs_low, hs_high, de_cnt;
      logic found, have_prev, prev_early;
      logic [7:0] pe_obs, pclk_obs;

      // ---------------- reset state ----------------
      repeat (3) @(negedge clk);
      check("rst_a_x", a_x, 0);
      check("rst_a_y", a_y, 0);
      check("rst_a_pe", a_pe, 0);
      check("rst_a_pclk", a_pclk, 0);
      check("rst_a_hs", a_hs, 1);
      check("rst_a_vs", a_vs, 1);
      check("rst_a_de", a_de, 0);
      check("rst_a_doe", a_doe, 0);
      check("rst_a_fc", a_fc, 0);
      check("rst_a_fs", a_fs, 0);
      check("rst_c_hs_pol1", c_hs, 0);
      check("rst_c_vs", c_vs, 1);

      // ---------------- default timing, first pixel ----------------
      rst_a = 1'b0;
      @(negedge clk);
      check("a_pe_not_yet", a_pe, 0);
      @(negedge clk);
      check("a_first_pe", a_pe, 1);
      check("a_first_fs", a_fs, 1);
      check("a_first_x", a_x, 0);
      check("a_first_y", a_y, 0);
      t0 = cyc;
      @(negedge clk);
      check("a_fc_after_fs", a_fc, 1);
      check("a_x_after_fs", a_x, 1);
      check("a_pe_low_after", a_pe, 0);

      gap = -1; first_hs_x = -1; de_fall_x = -1; de_rise_x = -1; hs_low = 0;
      early_bad = 0; delay_bad = 0; inv_bad = 0; pe_bad = 0; last_pe = -1;
      prev_x = 1; wrap_x = -1; wrap_y = -1; max_x = 0; found = 1'b0;
      have_prev = 1'b0; prev_early = 1'b0;
      for (int i = 0; i < 4000 && !found; i++) begin
         @(negedge clk);
         if (int'(a_x) > max_x) max_x = int'(a_x);
         if (prev_x == 799 && a_x != 10'd799 && wrap_x < 0) begin
            wrap_x = int'(a_x);
            wrap_y = int'(a_y);
         end
         prev_x = int'(a_x);
         if (a_pe && !a_hs && a_y == 10'd0) hs_low++;
         if (!a_hs && first_hs_x < 0) first_hs_x = int'(a_x);
         if (a_y == 10'd0 && !a_de && de_fall_x < 0) de_fall_x = int'(a_x);
         if (a_y == 10'd1 && a_de && de_rise_x < 0) de_rise_x = int'(a_x);
         if (a_ls && gap < 0) gap = cyc - t0;
         if (a_doe !== (a_x < 10'd640 && a_y < 10'd480)) early_bad++;
         if (a_doe && (!a_hs || !a_vs)) inv_bad++;
         if (a_pe) begin
            if (have_prev && a_de !== prev_early) delay_bad++;
            prev_early = a_doe;
            have_prev  = 1'b1;
            if (last_pe >= 0 && cyc - last_pe != 2) pe_bad++;
            last_pe = cyc;
         end
         if (a_x == 10'd300 && a_y == 10'd1) found = 1'b1;
      end
      check("a_reach_x300_y1", found, 1);
      check("a_pe_period_bad", pe_bad, 0);
      check("a_x_max", max_x, 799);
      check("a_wrap_x", wrap_x, 0);
      check("a_wrap_y", wrap_y, 1);
      check("a_line_clks", gap, 1600);
      check("a_hs_low_slots", hs_low, 96);
      check("a_hs_fall_x", first_hs_x, 657);
      check("a_de_fall_x", de_fall_x, 641);
      check("a_de_rise_x", de_rise_x, 1);
      check("a_early_bad", early_bad, 0);
      check("a_de_delay_bad", delay_bad, 0);
      check("a_sync_in_active", inv_bad, 0);

      // ---------------- reset mid-frame ----------------
      rst_a = 1'b1;
      @(negedge clk);
      check("a_midrst_x", a_x, 0);
      check("a_midrst_y", a_y, 0);
      check("a_midrst_hs", a_hs, 1);
      check("a_midrst_de", a_de, 0);
      check("a_midrst_fc", a_fc, 0);
      check("a_midrst_pe", a_pe, 0);
      rst_a = 1'b0;

      // ---------------- 4:1 divider, no alignment delay ----------------
      rst_b = 1'b0;
      first = -1;
      for (int i = 1; i <= 10 && first < 0; i++) begin
         @(negedge clk);
         if (b_pe) first = i;
      end
      check("b_first_pe_lat", first, 4);
      check("b_first_fs", b_fs, 1);
      pe_obs = '0; pclk_obs = '0;
      pe_obs[0] = b_pe; pclk_obs[0] = b_pclk;
      for (int k = 1; k < 8; k++) begin
         @(negedge clk);
         pe_obs[k]   = b_pe;
         pclk_obs[k] = b_pclk;
      end
      check("b_pe_pattern", pe_obs, 8'b0001_0001);
      check("b_pclk_pattern", pclk_obs, 8'b1100_1100);

      found = 1'b0;
      for (int i = 0; i < 3000 && !found; i++) begin
         @(negedge clk);
         if (b_x == 10'd640) found = 1'b1;
      end
      check("b_reach_x640", found, 1);
      check("b_doe_x640", b_doe, 0);
      check("b_de_x640_c0", b_de, 1);
      @(negedge clk);
      check("b_de_x640_c1", b_de, 0);
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (b_x == 10'd656) found = 1'b1;
      end
      check("b_reach_x656", found, 1);
      check("b_hs_x656_c0", b_hs, 1);
      @(negedge clk);
      check("b_hs_x656_c1", b_hs, 0);

      // ---------------- tiny raster, three frames ----------------
      rst_c = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (c_fs) found = 1'b1;
      end
      check("c_first_fs", found, 1);
      fs_n = 0; ls_n = 0; vs_low = 0; hs_high = 0; de_cnt = 0; inv_bad = 0;
      for (int i = 0; i < 960; i++) begin
         if (i > 0) @(negedge clk);
         if (c_fs) fs_n++;
         if (c_ls) ls_n++;
         if (c_doe && (c_hs || !c_vs)) inv_bad++;
         if (i < 320 && c_pe) begin
            if (!c_vs) vs_low++;
            if (c_hs) hs_high++;
            if (c_de) de_cnt++;
         end
      end
      @(negedge clk);
      check("c_frame_starts", fs_n, 3);
      check("c_line_starts", ls_n, 30);
      check("c_frame_cnt", c_fc, 3);
      check("c_next_fs", c_fs, 1);
      check("c_vs_low_slots", vs_low, 32);
      check("c_hs_high_slots", hs_high, 30);
      check("c_de_slots", de_cnt, 48);
      check("c_sync_in_active", inv_bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
